// File: rtl/ex_mdu_ctrl.sv
// EX-stage multiply/divide sequencer: radix-2 shift-add multiplier and restoring
// divider over 32 iterations, owning the HI/LO registers read by MFHI/MFLO.
module ex_mdu_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [5:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic        is_div;
  logic        div_zero;
  logic        neg_res;
  logic        neg_rem;
  logic [31:0] addend;
  logic [31:0] a_raw;
  logic [63:0] acc;

  logic        is_md;
  logic        is_signed;
  logic        is_dv;
  logic        start;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic [63:0] div_next;

  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  // Decode and accept
  always_comb begin
    is_md     = |op[3:0];
    is_signed = op[0] | op[2];
    is_dv     = op[2] | op[3];
    start     = in_valid & is_md & (state == IDLE) & ~cancel;
    a_mag     = (is_signed & src_a[31]) ? (~src_a + 32'd1) : src_a;
    b_mag     = (is_signed & src_b[31]) ? (~src_b + 32'd1) : src_b;
  end

  assign stall = (state == CALC) | start;
  assign done  = (state == FIX) & ~cancel;

  // One iteration step. acc holds {partial product, multiplier} for multiply
  // and {partial remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + {1'b0, addend};
    mul_next = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};
    rem_sh   = {acc[63:32], acc[31]};
    trial    = rem_sh - {1'b0, addend};
    div_next = trial[32] ? {rem_sh[31:0], acc[30:0], 1'b0}
                         : {trial[31:0], acc[30:0], 1'b1};
  end

  // Sign fixup and divide-by-zero override applied in the FIX cycle
  always_comb begin
    prod_fix = neg_res ? (~acc + 64'd1) : acc;
    quo_fix  = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem_fix  = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];
    fix_hi   = prod_fix[63:32];
    fix_lo   = prod_fix[31:0];
    if (is_div) begin
      if (div_zero) begin
        fix_hi = a_raw;
        fix_lo = '1;
      end else begin
        fix_hi = rem_fix;
        fix_lo = quo_fix;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      addend   <= '0;
      a_raw    <= '0;
      acc      <= '0;
    end else if (cancel) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CALC;
            cnt      <= '0;
            is_div   <= is_dv;
            div_zero <= is_dv & (src_b == '0);
            neg_res  <= is_signed & (src_a[31] ^ src_b[31]);
            neg_rem  <= is_signed & src_a[31];
            a_raw    <= src_a;
            addend   <= is_dv ? b_mag : a_mag;
            acc      <= is_dv ? {32'd0, a_mag} : {32'd0, b_mag};
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIX && !cancel) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end else if (state == IDLE && in_valid && !cancel) begin
      if (op[4]) hi <= src_a;
      if (op[5]) lo <= src_a;
    end
  end

endmodule

// File: tb/tb_ex_mdu_ctrl.sv
// Self-checking bench for ex_mdu_ctrl: directed spec cases plus randomized
// mul/div against an arithmetic reference model.
module tb_ex_mdu_ctrl;

  localparam logic [5:0] OP_MULT  = 6'b000001;
  localparam logic [5:0] OP_MULTU = 6'b000010;
  localparam logic [5:0] OP_DIV   = 6'b000100;
  localparam logic [5:0] OP_DIVU  = 6'b001000;
  localparam logic [5:0] OP_MTHI  = 6'b010000;
  localparam logic [5:0] OP_MTLO  = 6'b100000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [5:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  ex_mdu_ctrl dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .op(op),
    .src_a(src_a), .src_b(src_b), .cancel(cancel),
    .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero and
  // the remainder takes the dividend's sign, matching MIPS DIV.
  task automatic ref_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = '0;
    el = '0;
    if (o == OP_MULT) begin
      p = 64'(sa * sb);
      eh = p[63:32]; el = p[31:0];
    end else if (o == OP_MULTU) begin
      p = {32'd0, a} * {32'd0, b};
      eh = p[63:32]; el = p[31:0];
    end else if (b == 32'd0) begin
      eh = a; el = 32'hFFFFFFFF;
    end else if (o == OP_DIV) begin
      q = sa / sb; r = sa % sb;
      el = q[31:0]; eh = r[31:0];
    end else begin
      el = a / b; eh = a % b;
    end
  endtask

  // Full operation from accept to result; garbage inputs are driven while busy.
  task automatic do_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input string name);
    tick();
    in_valid = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: stall=%b done=%b, want stall=1 done=0", name, stall, done);
    end
    tick();
    for (int i = 1; i <= 33; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      op = 6'(1) << $urandom_range(0, 5);
      src_a = $urandom; src_b = $urandom;
      @(negedge clk);
      checks++;
      if (stall !== (i <= 32) || done !== (i == 33) || hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL %s cycle T+%0d: stall=%b done=%b hi=%h lo=%h, want stall=%b done=%b hi=%h lo=%h",
                 name, i, stall, done, hi, lo, (i <= 32), (i == 33), m_hi, m_lo);
      end
      tick();
    end
    in_valid = 1'b0; op = '0;
    m_hi = eh; m_lo = el;
    @(negedge clk);
    checks++;
    if (hi !== eh || lo !== el || stall !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s result: hi=%h lo=%h stall=%b done=%b, want hi=%h lo=%h stall=0 done=0",
               name, hi, lo, stall, done, eh, el);
    end
  endtask

  task automatic do_mt(input logic [5:0] o, input logic [31:0] a, input string name);
    tick();
    in_valid = 1'b1; op = o; src_a = a;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s issue: stall=%b done=%b, want 0 0", name, stall, done);
    end
    tick();
    in_valid = 1'b0; op = '0;
    if (o == OP_MTHI) m_hi = a; else m_lo = a;
    @(negedge clk);
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL %s write: hi=%h lo=%h, want hi=%h lo=%h", name, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; op = '0; src_a = '0; src_b = '0; cancel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
        errors++;
        $display("FAIL reset_state: stall=%b done=%b hi=%h lo=%h, want 0 0 0 0", stall, done, hi, lo);
      end
    end
  endtask

  task automatic test_mul_directed();
    do_op(OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg3x5");
    do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
    do_op(OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minmin");
  endtask

  task automatic test_div_directed();
    do_op(OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2");
    do_op(OP_DIVU, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, "divu_100by7");
    do_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_overflow");
  endtask

  task automatic test_div_zero();
    do_op(OP_DIVU, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF, "divu_by_zero");
    do_op(OP_DIV,  32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, "div_by_zero_neg");
  endtask

  task automatic test_cancel_calc();
    do_mt(OP_MTHI, 32'hAAAA5555, "mthi");
    do_mt(OP_MTLO, 32'h5555AAAA, "mtlo");
    tick();
    in_valid = 1'b1; op = OP_DIV; src_a = 32'd9; src_b = 32'd3;
    tick();
    in_valid = 1'b0; op = '0;
    repeat (9) tick();
    cancel = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL cancel_T10: stall=%b done=%b, want 1 0", stall, done);
    end
    tick();
    cancel = 1'b0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL cancel_after %0d: stall=%b done=%b hi=%h lo=%h, want 0 0 %h %h",
                 i, stall, done, hi, lo, m_hi, m_lo);
      end
      tick();
    end
  endtask

  task automatic test_cancel_edges();
    // cancel alongside accept and alongside MTHI: neither takes effect
    tick();
    in_valid = 1'b1; op = OP_DIV; src_a = 32'd50; src_b = 32'd5; cancel = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL cancel_accept: stall=%b, want 0", stall);
    end
    tick();
    op = OP_MTHI; src_a = 32'hDEADBEEF;
    tick();
    in_valid = 1'b0; op = '0; cancel = 1'b0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL cancel_accept_after %0d: stall=%b done=%b hi=%h lo=%h, want 0 0 %h %h",
                 i, stall, done, hi, lo, m_hi, m_lo);
      end
      tick();
    end
    // cancel in the FIX cycle suppresses the write
    in_valid = 1'b1; op = OP_MULTU; src_a = 32'd1000; src_b = 32'd1000;
    tick();
    in_valid = 1'b0; op = '0;
    repeat (32) tick();
    cancel = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL cancel_fix: done=%b stall=%b, want 0 0", done, stall);
    end
    tick();
    cancel = 1'b0;
    @(negedge clk);
    checks++;
    if (hi !== m_hi || lo !== m_lo || stall !== 1'b0) begin
      errors++;
      $display("FAIL cancel_fix_hilo: hi=%h lo=%h stall=%b, want %h %h 0", hi, lo, stall, m_hi, m_lo);
    end
  endtask

  task automatic test_async_reset();
    tick();
    in_valid = 1'b1; op = OP_MULT; src_a = 32'd7; src_b = 32'd9;
    tick();
    in_valid = 1'b0; op = '0;
    repeat (5) tick();
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    checks++;
    if (stall !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: stall=%b done=%b hi=%h lo=%h, want 0 0 0 0", stall, done, hi, lo);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 resetn = 1'b1;
    do_op(OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, "mult_after_reset");
  endtask

  task automatic test_random();
    logic [5:0]  o;
    logic [31:0] a, b, eh, el;
    for (int n = 0; n < 24; n++) begin
      o = 6'(1) << $urandom_range(0, 3);
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      ref_op(o, a, b, eh, el);
      do_op(o, a, b, eh, el, $sformatf("rand%0d_op%b", n, o));
    end
  endtask

  initial begin
    test_reset();
    test_mul_directed();
    test_div_directed();
    test_div_zero();
    test_cancel_calc();
    test_cancel_edges();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mdu_ctrl.md
Name: ex_mdu_ctrl

Overview:
Multi-cycle multiply/divide sequencer and HI/LO register owner for the EX stage of the 5-stage MIPS core. It sits beside the EX ALU and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX. It runs a radix-2 iterative shift-add multiplier or restoring divider over 32 cycles and stalls the pipeline while doing so. Results land in HI/LO, which are read combinationally by MFHI/MFLO in EX.

Parameters:
None; operand width is fixed at 32.

Ports:
clk        in   1   core clock, rising edge
resetn     in   1   reset, asynchronous, active-low
in_valid   in   1   EX holds a valid instruction this cycle
op         in   6   one-hot: [0]MULT [1]MULTU [2]DIV [3]DIVU [4]MTHI [5]MTLO; all-zero = no action
src_a      in   32  rs value (dividend / multiplicand / MTHI-MTLO data)
src_b      in   32  rt value (divisor / multiplier)
cancel     in   1   flush from exception/eret; kills the current operation
stall      out  1   EX must hold; combinational
done       out  1   one-cycle pulse in the cycle HI/LO are written
hi         out  32  HI register
lo         out  32  LO register

Behaviour:
- Reset (resetn low, async):
  - state=IDLE, hi=0, lo=0, done=0.
  - Internal counter and operand registers are cleared.
- States:
  - IDLE -> CALC on accept of a MULT/MULTU/DIV/DIVU.
  - CALC runs 32 iterations, counter 0..31, then -> FIX.
  - FIX -> IDLE unconditionally.
  - Any state -> IDLE on cancel=1 at the clock edge.
- Accept (cycle T): in_valid & (op[3:0]!=0) & state==IDLE & !cancel.
  - Latch |src_a| and |src_b| for signed ops (raw values for unsigned).
  - Latch the sign of src_a and the sign of src_a^src_b.
- stall = (state==CALC) | (state==IDLE & in_valid & op[3:0]!=0 & !cancel).
  - High cycles T..T+32 (33 cycles).
  - Low in the FIX cycle (T+33), so the instruction leaves EX on the same edge that writes HI/LO.
- FIX (cycle T+33):
  - Apply sign fixup. Product is negated if the operand signs differ (MULT only).
  - For DIV: quotient is negated if signs differ; remainder takes the sign of the dividend.
  - done=1. HI/LO take the new values at the end of T+33, so they are visible from T+34.
- Multiply: 64-bit result, HI=product[63:32], LO=product[31:0].
- Divide: LO=quotient, HI=remainder.
- Divide by zero (src_b==0, DIV or DIVU): no trap. Forced result LO=32'hFFFFFFFF, HI=src_a as latched at accept (original signed value), still 33-cycle latency.
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- MTHI/MTLO: in_valid & op[4]/op[5] & !cancel & state==IDLE writes hi/lo from src_a at the next edge.
  - No stall, no done.
- cancel:
  - Returns to IDLE at the next edge; HI/LO are not written; done stays 0.
  - cancel in the accept cycle prevents the start.
  - cancel in the FIX cycle suppresses the HI/LO write.
- Inputs are ignored whenever state!=IDLE. EX is stalled then, so no new op can legally arrive.
- More than one op bit set is illegal (verification asserts op is $onehot0 when in_valid).

Test Plan:
- Reset release, no ops -> hi=0, lo=0, stall=0, done=0.
- MULT src_a=0xFFFFFFFD, src_b=5 at T -> stall high T..T+32, done at T+33; from T+34 hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7/2 (0xFFFFFFF9, 2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/7 -> lo=0x0000000E, hi=0x00000002.
- DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x00001234.
- Preload via MTHI 0xAAAA5555, then MTLO 0x5555AAAA (each visible next cycle, stall=0). Start DIV 9/3, assert cancel at T+10 -> stall low from T+11, done never pulses, hi/lo keep the preload values.
- Pull resetn low mid-CALC (asynchronously, between edges) -> immediately stall=0, hi=lo=0. Then MULT 3*4 -> lo=12, hi=0.
